window_feature_extractor: RTL and testbench
===========================================

# window_feature_extractor

Streaming feature-extraction stage that sits directly downstream of the sample counter in the sensor front-end. It accepts unsigned sensor samples over a valid/ready handshake and groups them into fixed windows of 2^WIN_LOG2 samples. At the end of each window it emits the window's sum, min, max and mean to the classifier input. The position within the current window is exposed as a free-running index, which lets the classifier sequencer align to window boundaries.

## Interface
- DATA_W, 8: sample width, unsigned.
- WIN_LOG2, 2: log2 of the window length. The window holds 2^WIN_LOG2 samples; WIN_LOG2 ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; abandons a partial window.
- in_valid  in  1  sample present.
- in_data  in  DATA_W  sample value.
- in_ready  out  1  block can accept a sample.
- sample_idx  out  WIN_LOG2  number of samples already accepted in the current window.
- out_valid  out  1  window result held.
- out_ready  in  1  consumer takes the result.
- out_sum  out  DATA_W+WIN_LOG2  sum of the window's samples.
- out_min  out  DATA_W  minimum sample.
- out_max  out  DATA_W  maximum sample.
- out_mean  out  DATA_W  out_sum >> WIN_LOG2, truncated.

## Operation
- The block has two states:
  - ACCUM: accepting samples; in_ready = 1, out_valid = 0.
  - HOLD: result held; in_ready = 0, out_valid = 1.
- A sample is accepted when in_valid && in_ready at a rising edge. On acceptance:
  - acc_sum += in_data.
  - acc_min = min(acc_min, in_data); acc_max = max(acc_max, in_data).
  - sample_idx increments.
- First sample of a window (sample_idx == 0): acc_min and acc_max load in_data directly; no comparison against stale values.
- Last sample of a window (sample_idx == 2^WIN_LOG2−1), on acceptance:
  - Outputs register the final sum/min/max/mean, with the last sample included.
  - sample_idx wraps to 0.
  - State goes to HOLD.
- HOLD with out_ready = 1 at an edge:
  - Result is consumed; the next state is ACCUM.
  - Accumulators clear.
  - Output data registers keep their last values (don't-care while out_valid = 0).
- HOLD with out_ready = 0: all outputs stable, no sample is accepted, in_data is ignored.
- flush in ACCUM:
  - acc_sum, sample_idx, acc_min and acc_max clear to 0.
  - Any in_valid sample in the same cycle is discarded; flush wins.
- flush in HOLD: ignored. The held result must still be consumed.
- Arithmetic:
  - Everything is unsigned.
  - The sum width DATA_W+WIN_LOG2 cannot overflow.
  - Mean is a right shift of the sum; no rounding.
- Reset values: in_ready = 1 (state ACCUM). out_valid, sample_idx, out_sum, out_min, out_max, out_mean, acc_sum, acc_min and acc_max are all 0.

## Timing
- in_ready and out_valid are decoded from registered state only; neither depends combinationally on in_valid or out_ready.
- Latency: out_valid rises on the edge that accepts the last sample, and is visible the following cycle.
- Throughput: one window per 2^WIN_LOG2 + 1 cycles minimum. There is one HOLD cycle even with out_ready tied high, because there is no same-cycle accept-while-emit.
- out_ready is sampled only in HOLD; it has no effect in ACCUM.
- Asserting rst mid-window or mid-HOLD clears everything immediately, regardless of clk. A pending result is lost.
- After rst deasserts, the first accepted sample is sample 0 of a fresh window.
- in_valid may drop between samples. Gaps stall accumulation without loss, and sample_idx holds during gaps.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> in_ready = 1, out_valid = 0, sample_idx = 0, all outputs 0 with no clock edge needed.
- Basic window (DATA_W=8, WIN_LOG2=2): samples 10, 200, 3, 50 back-to-back, out_ready = 1 -> out_valid for exactly 1 cycle. Result: out_sum = 263, out_min = 3, out_max = 200, out_mean = 65. sample_idx sequence 0, 1, 2, 3, 0.
- Saturation boundary: four samples of 255 -> out_sum = 1020, out_mean = 255, min = max = 255. Then four samples of 0 -> sum 0, min 0, max 0; no stale min/max carried over.
- Backpressure: complete a window with out_ready = 0 for 5 cycles while in_valid = 1 and in_data is changing -> in_ready = 0 and outputs stable throughout. On the out_ready pulse: a single handshake, then the next window starts cleanly.
- Flush and gaps: accept 2 samples (7, 9), flush together with in_valid carrying 100 -> sample_idx = 0 and 100 discarded. Then 1, 2, 3, 4 with 1-cycle gaps -> sum 10, min 1, max 4, mean 2.
- Reset mid-window: accept 3 samples, then pulse rst -> no out_valid is emitted. The next 4 samples form a correct window.

Source files
------------

// File: rtl/window_feature_extractor.sv
// Streaming window statistics: groups 2^WIN_LOG2 unsigned samples and emits
// sum/min/max/mean through a one-entry valid/ready result holding register.
module window_feature_extractor #(
    parameter int DATA_W   = 8,
    parameter int WIN_LOG2 = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic [WIN_LOG2-1:0]        sample_idx,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W+WIN_LOG2-1:0] out_sum,
    output logic [DATA_W-1:0]          out_min,
    output logic [DATA_W-1:0]          out_max,
    output logic [DATA_W-1:0]          out_mean
);
    localparam int SUM_W = DATA_W + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] IDX_ONE = 1;

    typedef enum logic {ACCUM, HOLD} state_t;
    state_t state, state_nxt;

    logic              accept, consume, first, last;
    logic [SUM_W-1:0]  acc_sum, sum_nxt;
    logic [DATA_W-1:0] acc_min, acc_max, min_nxt, max_nxt;

    assign first = (sample_idx == '0);
    assign last  = (sample_idx == '1);

    // The first sample loads min/max directly so stale values never leak in.
    assign sum_nxt = acc_sum + SUM_W'(in_data);
    assign min_nxt = (first || in_data < acc_min) ? in_data : acc_min;
    assign max_nxt = (first || in_data > acc_max) ? in_data : acc_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        consume   = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid && !flush;
                if (accept && last) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                consume   = out_ready;
                if (out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_sum    <= '0;
            acc_min    <= '0;
            acc_max    <= '0;
            sample_idx <= '0;
            out_sum    <= '0;
            out_min    <= '0;
            out_max    <= '0;
            out_mean   <= '0;
        end else if (flush && state == ACCUM) begin
            acc_sum    <= '0;
            acc_min    <= '0;
            acc_max    <= '0;
            sample_idx <= '0;
        end else if (accept) begin
            acc_sum    <= sum_nxt;
            acc_min    <= min_nxt;
            acc_max    <= max_nxt;
            sample_idx <= sample_idx + IDX_ONE;
            if (last) begin
                out_sum  <= sum_nxt;
                out_min  <= min_nxt;
                out_max  <= max_nxt;
                out_mean <= sum_nxt[SUM_W-1:WIN_LOG2];
            end
        end else if (consume) begin
            acc_sum <= '0;
            acc_min <= '0;
            acc_max <= '0;
        end
    end
endmodule

// File: tb/tb_window_feature_extractor.sv
// Directed test-plan sequences plus randomized traffic against a queue-based
// window model; every cycle compares handshake, index and result outputs.
module tb_window_feature_extractor;
    localparam int DATA_W   = 8;
    localparam int WIN_LOG2 = 2;
    localparam int WIN      = 1 << WIN_LOG2;

    logic                       clk = 0;
    logic                       rst = 1;
    logic                       flush = 0;
    logic                       in_valid = 0;
    logic [DATA_W-1:0]          in_data = 0;
    logic                       in_ready;
    logic [WIN_LOG2-1:0]        sample_idx;
    logic                       out_valid;
    logic                       out_ready = 0;
    logic [DATA_W+WIN_LOG2-1:0] out_sum;
    logic [DATA_W-1:0]          out_min, out_max, out_mean;

    window_feature_extractor #(.DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .sample_idx(sample_idx), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_min(out_min),
        .out_max(out_max), .out_mean(out_mean)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: accepted samples of the open window, plus the held result.
    int win_q[$];
    bit m_held;
    int m_sum, m_min, m_max, m_mean;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        win_q.delete();
        m_held = 0;
        m_sum = 0; m_min = 0; m_max = 0; m_mean = 0;
    endfunction

    function automatic void model_edge();
        if (!m_held) begin
            if (flush) win_q.delete();
            else if (in_valid) begin
                win_q.push_back(int'(in_data));
                if (win_q.size() == WIN) begin
                    m_sum = 0; m_min = 1 << DATA_W; m_max = -1;
                    foreach (win_q[i]) begin
                        m_sum += win_q[i];
                        if (win_q[i] < m_min) m_min = win_q[i];
                        if (win_q[i] > m_max) m_max = win_q[i];
                    end
                    m_mean = m_sum / WIN;
                    m_held = 1;
                    win_q.delete();
                end
            end
        end else if (out_ready) begin
            m_held = 0;
        end
    endfunction

    task automatic check_all();
        chk("in_ready",   int'(in_ready),   int'(!m_held));
        chk("out_valid",  int'(out_valid),  int'(m_held));
        chk("sample_idx", int'(sample_idx), win_q.size());
        chk("out_sum",    int'(out_sum),    m_sum);
        chk("out_min",    int'(out_min),    m_min);
        chk("out_max",    int'(out_max),    m_max);
        chk("out_mean",   int'(out_mean),   m_mean);
    endtask

    task automatic step(input bit v, input int d, input bit f, input bit r);
        in_valid = v; in_data = DATA_W'(d); flush = f; out_ready = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #2 rst = 1;
        #1;
        model_reset();
        check_all();
        #1 rst = 0;
    endtask

    initial begin
        model_reset();
        #3;
        check_all();
        @(posedge clk); #1 rst = 0;
        async_reset();

        // Basic window with out_ready tied high: one HOLD cycle.
        step(1, 10, 0, 1); step(1, 200, 0, 1); step(1, 3, 0, 1);
        chk("basic_idx3", int'(sample_idx), 3);
        step(1, 50, 0, 1);
        chk("basic_sum", int'(out_sum), 263);
        chk("basic_mean", int'(out_mean), 65);
        step(1, 99, 0, 1);
        chk("basic_valid_drop", int'(out_valid), 0);

        // Full-scale then all-zero windows.
        repeat (WIN) step(1, 255, 0, 1);
        chk("sat_sum", int'(out_sum), 1020);
        step(0, 0, 0, 1);
        repeat (WIN) step(1, 0, 0, 1);
        chk("zero_max", int'(out_max), 0);
        step(0, 0, 0, 1);

        // Backpressure with changing input data while held.
        for (int i = 0; i < WIN; i++) step(1, 20 + i, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 77 * i, 0, 0);
        step(1, 5, 0, 1);
        for (int i = 0; i < WIN; i++) step(1, 40 + i, 0, 1);
        step(0, 0, 0, 1);

        // Flush beats a same-cycle sample; gapped window afterwards.
        step(1, 7, 0, 0); step(1, 9, 0, 0); step(1, 100, 1, 0);
        chk("flush_idx", int'(sample_idx), 0);
        for (int i = 1; i <= WIN; i++) begin
            step(1, i, 0, 0);
            step(0, 0, 0, 0);
        end
        chk("gap_sum", int'(out_sum), 10);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);

        // Reset in the middle of a window.
        step(1, 1, 0, 1); step(1, 2, 0, 1); step(1, 3, 0, 1);
        async_reset();
        for (int i = 0; i < WIN; i++) step(1, 60 + i, 0, 1);
        step(0, 0, 0, 1);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            int d;
            case ($urandom_range(0, 3))
                0: d = 0;
                1: d = 255;
                default: d = int'($urandom_range(0, 255));
            endcase
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
